// File: rtl/alu_32b_if.sv
// rtl/alu_32b_if.sv - operand/op/result bundle for the 32-bit ALU
interface alu_32b_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] result;
    logic             carry_out;

    modport master (
        output a, b, carry_in, alu_op,
        input  result, carry_out
    );

    modport slave (
        input  a, b, carry_in, alu_op,
        output result, carry_out
    );
endinterface

// File: rtl/alu_32b.sv
// rtl/alu_32b.sv - registered 32-bit ALU with bit-sliced ripple-carry adder
// Optional feature macro: ALU_SLT_EN (op 111 = signed set-less-than).
module alu_32b #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    alu_32b_if.slave   bus
);
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    logic             sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] next_result;
    logic             next_carry;
    logic [WIDTH-1:0] result_q;
    logic             carry_q;

    // SUB and SLT share the a + ~b + 1 path; carry_in only feeds ADD.
    assign sub      = (bus.alu_op == OP_SUB) || (bus.alu_op == OP_SLT);
    assign carry[0] = sub ? 1'b1 : bus.carry_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        assign b_eff[i]   = bus.b[i] ^ sub;
        assign sum[i]     = bus.a[i] ^ b_eff[i] ^ carry[i];
        assign carry[i+1] = (bus.a[i] & b_eff[i]) | (carry[i] & (bus.a[i] ^ b_eff[i]));
    end

`ifdef ALU_SLT_EN
    logic slt_bit;
    // Sign of a-b, flipped when the subtraction overflowed.
    assign slt_bit = sum[WIDTH-1] ^ (carry[WIDTH] ^ carry[WIDTH-1]);
`endif

    always_comb begin
        next_result = '0;
        next_carry  = 1'b0;
        case (bus.alu_op)
            OP_AND: next_result = bus.a & bus.b;
            OP_OR:  next_result = bus.a | bus.b;
            OP_ADD: begin
                next_result = sum;
                next_carry  = carry[WIDTH];
            end
            OP_XOR: next_result = bus.a ^ bus.b;
            OP_NOR: next_result = ~(bus.a | bus.b);
            OP_SUB: begin
                next_result = sum;
                next_carry  = carry[WIDTH];
            end
`ifdef ALU_SLT_EN
            OP_SLT: next_result = {{(WIDTH-1){1'b0}}, slt_bit};
`else
            OP_SLT: next_result = '0;
`endif
            default: begin
                next_result = '0;
                next_carry  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            result_q <= next_result;
            carry_q  <= next_carry;
        end
    end

    assign bus.result    = result_q;
    assign bus.carry_out = carry_q;
endmodule

// File: tb/tb_alu_32b.sv
// tb/tb_alu_32b.sv - self-checking bench for alu_32b against an arithmetic reference
module tb_alu_32b;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    alu_32b_if #(.WIDTH(32)) bus ();

    alu_32b #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [32:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic cin);
        logic [32:0] r;
        case (op)
            3'd0: r = {1'b0, a & b};
            3'd1: r = {1'b0, a | b};
            3'd2: r = {1'b0, a} + {1'b0, b} + {32'd0, cin};
            3'd3: r = {1'b0, a ^ b};
            3'd4: r = {1'b0, ~(a | b)};
            3'd6: r = {1'b0, a} + {1'b0, ~b} + 33'd1;
`ifdef ALU_SLT_EN
            3'd7: r = ($signed(a) < $signed(b)) ? 33'd1 : 33'd0;
`endif
            default: r = 33'd0;
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] exp_r, input logic exp_c);
        checks++;
        assert (bus.result === exp_r) else begin
            errors++;
            $error("FAIL %s result: got %h expected %h", tag, bus.result, exp_r);
        end
        checks++;
        assert (bus.carry_out === exp_c) else begin
            errors++;
            $error("FAIL %s carry_out: got %b expected %b", tag, bus.carry_out, exp_c);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic cin);
        @(negedge clk);
        bus.alu_op   = op;
        bus.a        = a;
        bus.b        = b;
        bus.carry_in = cin;
    endtask

    task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic cin);
        logic [32:0] e;
        drive(op, a, b, cin);
        e = ref_alu(op, a, b, cin);
        @(posedge clk);
        #1;
        check(tag, e[31:0], e[32]);
    endtask

    task automatic run_exp(input string tag, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic cin,
                           input logic [31:0] exp_r, input logic exp_c);
        drive(op, a, b, cin);
        @(posedge clk);
        #1;
        check(tag, exp_r, exp_c);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] slt_exp;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.a = '0;
        bus.b = '0;
        bus.carry_in = 1'b0;
        bus.alu_op = 3'd0;
        #1;
        check("reset_state", 32'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        run_exp("and_11", 3'b000, 32'd1, 32'd1, 1'b0, 32'd1, 1'b0);
        run_exp("and_10", 3'b000, 32'd1, 32'd0, 1'b0, 32'd0, 1'b0);
        run_exp("and_00", 3'b000, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
        run_exp("or_10",  3'b001, 32'd1, 32'd0, 1'b0, 32'd1, 1'b0);
        run_exp("or_01",  3'b001, 32'd0, 32'd1, 1'b0, 32'd1, 1'b0);
        run_exp("or_00",  3'b001, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
        run_exp("add_11", 3'b010, 32'd1, 32'd1, 1'b0, 32'd2, 1'b0);
        run_exp("add_wrap", 3'b010, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 1'b1);
        run_exp("add_cin", 3'b010, 32'd1, 32'd0, 1'b1, 32'd2, 1'b0);
        run_exp("sub_5_3", 3'b110, 32'd5, 32'd3, 1'b0, 32'd2, 1'b1);
        run_exp("sub_3_5", 3'b110, 32'd3, 32'd5, 1'b0, 32'hFFFF_FFFE, 1'b0);
        run_exp("sub_cin_ignored", 3'b110, 32'd5, 32'd3, 1'b1, 32'd2, 1'b1);
        run_exp("rsvd_101", 3'b101, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 32'd0, 1'b0);
`ifdef ALU_SLT_EN
        slt_exp = 32'd1;
`else
        slt_exp = 32'd0;
`endif
        run_exp("slt_m1_1", 3'b111, 32'hFFFF_FFFF, 32'd1, 1'b0, slt_exp, 1'b0);
        run_exp("slt_1_m1", 3'b111, 32'd1, 32'hFFFF_FFFF, 1'b0, 32'd0, 1'b0);

        // Asynchronous reset asserted mid-cycle, then released.
        run_exp("pre_reset_add", 3'b010, 32'd1, 32'd1, 1'b0, 32'd2, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", 32'd0, 1'b0);
        @(posedge clk);
        #1;
        check("reset_held", 32'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("after_release", 32'd2, 1'b0);

        for (int i = 0; i < 400; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: ra = 32'hFFFF_FFFF;
                1: rb = 32'h8000_0000;
                2: rb = ra;
                3: ra = 32'h7FFF_FFFF;
                default: ;
            endcase
            run("random", 3'($urandom_range(0, 7)), ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
